vend_select_ctrl: RTL and testbench
===================================

Name: vend_select_ctrl

Overview:
- Vending-machine transaction controller; sits directly upstream of the 3-to-8 product decoder.
- Accumulates coin credit and accepts a 3-bit product selection.
- When credit covers the price, drives the selection code on sel1..sel3 and holds dispense_en high for a fixed window; sel1..sel3 feed the decoder's select inputs and dispense_en feeds its enable.
- Returns leftover credit as a one-cycle change report.

Parameters:
- CREDIT_W, 6, credit/change register width.
- MAX_CREDIT, 63, saturation ceiling for credit (≤ 2^CREDIT_W-1).
- PRICE, 15, uniform item price in credit units (1..MAX_CREDIT).
- DISPENSE_CYCLES, 4, cycles dispense_en is held high (≥1).
- TIMEOUT_CYCLES, 1000, idle cycles before auto-refund (used only with VEND_AUTO_REFUND_EN).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- coin_5  input  1  one-cycle pulse, +5 credit.
- coin_10  input  1  one-cycle pulse, +10 credit.
- item_valid  input  1  one-cycle pulse, selection request.
- item_code  input  3  product index 0..7, sampled when item_valid=1.
- cancel  input  1  one-cycle pulse, refund request.
- sel1  output  1  item_code[0], to decoder.
- sel2  output  1  item_code[1], to decoder.
- sel3  output  1  item_code[2], to decoder.
- dispense_en  output  1  decoder enable.
- busy  output  1  1 whenever state != IDLE.
- credit  output  CREDIT_W  current credit.
- coin_reject  output  1  one-cycle pulse, coin not accepted.
- deny  output  1  one-cycle pulse, selection refused (insufficient credit).
- change_valid  output  1  one-cycle pulse, change_amt valid.
- change_amt  output  CREDIT_W  refunded amount; 0 when change_valid=0.

Behaviour:
- All outputs registered.
- Reset (rst_n=0 at a clk edge): state=IDLE; all outputs 0. This includes reset mid-DISPENSE: dispense_en drops next edge and credit is discarded.
- States: IDLE, DISPENSE, CHANGE.
- IDLE, per-cycle priority:
  - cancel first: if credit>0, go to CHANGE; if credit=0, no action.
  - then item_valid:
    - credit>=PRICE: latch item_code to sel3..sel1, credit-=PRICE, dispense_en=1 next cycle, go to DISPENSE.
    - otherwise: deny=1 next cycle, state unchanged.
  - then coins: add 5 or 10 (15 if both asserted) only if no cancel or accepted item that cycle and the sum ≤ MAX_CREDIT. Otherwise coin_reject=1 next cycle and credit unchanged. A coin arriving with a denied item is still added.
- DISPENSE:
  - dispense_en and sel held stable for exactly DISPENSE_CYCLES cycles, counted from the first high cycle.
  - After the last cycle: dispense_en=0, sel=000. Go to CHANGE if credit>0, else IDLE.
  - cancel and item_valid are ignored; coins produce coin_reject.
- CHANGE (one cycle):
  - change_valid=1, change_amt=credit, credit=0; return to IDLE.
  - Coins produce coin_reject; item and cancel are ignored.
- Latency:
  - item_valid at edge N gives dispense_en high at N+1..N+DISPENSE_CYCLES; change_valid at N+DISPENSE_CYCLES+1.
  - cancel at N gives change_valid at N+1, state CHANGE, and IDLE at N+2.
- dispense_en is never high outside DISPENSE. sel is 000 whenever dispense_en=0.

Optional Feature:
- Macro VEND_AUTO_REFUND_EN.
- Defined:
  - Idle counter counts cycles in IDLE with credit>0 and no coin/item/cancel pulse.
  - Any pulse or leaving IDLE clears the counter.
  - On reaching TIMEOUT_CYCLES, go to CHANGE, identical to cancel.
- Not defined: no counter; credit is held indefinitely. TIMEOUT_CYCLES is unused.

Test Plan:
- Reset then coin_10, coin_5, item_valid code=5 → credit 10, 15, then 0; sel3..1=101, dispense_en high 4 cycles; no change_valid; busy low afterwards.
- coin_10 ×2, item_valid code=2 → dispense 4 cycles with sel=010, then change_valid=1, change_amt=5, credit=0.
- coin_5 then item_valid code=7 → deny pulse, credit stays 5, dispense_en stays 0; then cancel → change_valid, change_amt=5.
- Credit 60, coin_5 → coin_reject, credit 60. Coin_10 during DISPENSE → coin_reject, credit unchanged.
- Same cycle: cancel+item_valid with credit 20 → CHANGE with change_amt=20, no dispense. Separate case: item_valid+coin_10 with credit 15 → dispense and coin_reject.
- rst_n=0 during the 2nd dispense cycle → dispense_en=0, credit=0, state IDLE on that edge. With VEND_AUTO_REFUND_EN and TIMEOUT_CYCLES=8, credit 5 untouched for 8 cycles → change_amt=5.

Source files
------------

// File: rtl/vend_select_ctrl.sv
// vend_select_ctrl: vending-machine transaction controller, upstream of the 3-to-8 product
// decoder. Accumulates coin credit, accepts a 3-bit selection, drives the selection code and a
// fixed-length dispense enable, and reports leftover credit as a one-cycle change pulse.
//
// Optional feature macro: VEND_AUTO_REFUND_EN. When defined, an idle counter refunds credit
// after TIMEOUT_CYCLES untouched idle cycles. When undefined, credit is held indefinitely and
// TIMEOUT_CYCLES is unused.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        synchronous active-low reset
//   i_coin_5       one-cycle pulse, +5 credit
//   i_coin_10      one-cycle pulse, +10 credit
//   i_item_valid   one-cycle pulse, selection request
//   i_item_code    product index, sampled with i_item_valid
//   i_cancel       one-cycle pulse, refund request
//   o_sel1..o_sel3 latched item_code[0..2], 000 whenever o_dispense_en is low
//   o_dispense_en  decoder enable, high for DISPENSE_CYCLES cycles per vend
//   o_busy         high whenever the controller is not idle
//   o_credit       current credit
//   o_coin_reject  one-cycle pulse, coin not accepted
//   o_deny         one-cycle pulse, selection refused for insufficient credit
//   o_change_valid one-cycle pulse, o_change_amt valid
//   o_change_amt   refunded amount, 0 when o_change_valid is low
module vend_select_ctrl #(
  parameter int unsigned CREDIT_W        = 6,
  parameter int unsigned MAX_CREDIT      = 63,
  parameter int unsigned PRICE           = 15,
  parameter int unsigned DISPENSE_CYCLES = 4,
  parameter int unsigned TIMEOUT_CYCLES  = 1000
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_coin_5,
  input  logic                i_coin_10,
  input  logic                i_item_valid,
  input  logic [2:0]          i_item_code,
  input  logic                i_cancel,
  output logic                o_sel1,
  output logic                o_sel2,
  output logic                o_sel3,
  output logic                o_dispense_en,
  output logic                o_busy,
  output logic [CREDIT_W-1:0] o_credit,
  output logic                o_coin_reject,
  output logic                o_deny,
  output logic                o_change_valid,
  output logic [CREDIT_W-1:0] o_change_amt
);

  typedef enum logic [1:0] {StIdle, StDispense, StChange} state_e;

  // Extra headroom so credit + 15 never wraps before the ceiling compare.
  localparam int unsigned SumW  = CREDIT_W + 5;
  localparam int unsigned DispW = (DISPENSE_CYCLES > 1) ? $clog2(DISPENSE_CYCLES) : 1;

  localparam logic [CREDIT_W-1:0] PriceC   = CREDIT_W'(PRICE);
  localparam logic [SumW-1:0]     MaxC     = SumW'(MAX_CREDIT);
  localparam logic [DispW-1:0]    DispLoad = DispW'(DISPENSE_CYCLES - 1);

  state_e              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [2:0]          r_sel;
  logic [DispW-1:0]    r_disp_cnt;
  logic                r_dispense_en;
  logic                r_busy;
  logic                r_coin_reject;
  logic                r_deny;
  logic                r_change_valid;
  logic [CREDIT_W-1:0] r_change_amt;

  logic                w_coin_any;
  logic [SumW-1:0]     w_coin_amt;
  logic [SumW-1:0]     w_sum;
  logic                w_coin_fits;
  logic                w_credit_nz;
  logic                w_item_ok;
  logic                w_refund;

  assign w_coin_any  = i_coin_5 | i_coin_10;
  assign w_coin_amt  = (i_coin_5 ? SumW'(5) : '0) + (i_coin_10 ? SumW'(10) : '0);
  assign w_sum       = SumW'(r_credit) + w_coin_amt;
  assign w_coin_fits = (w_sum <= MaxC);
  assign w_credit_nz = |r_credit;
  assign w_item_ok   = i_item_valid && (r_credit >= PriceC);

`ifdef VEND_AUTO_REFUND_EN
  localparam int unsigned TimeoutW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TimeoutW-1:0] TimeoutLast = TimeoutW'(TIMEOUT_CYCLES - 1);

  logic [TimeoutW-1:0] r_idle_cnt;
  logic                w_pulse;
  logic                w_timeout;

  assign w_pulse   = w_coin_any | i_item_valid | i_cancel;
  // Fires on the TIMEOUT_CYCLES-th consecutive untouched idle cycle with credit held.
  assign w_timeout = (r_state == StIdle) && w_credit_nz && !w_pulse && (r_idle_cnt == TimeoutLast);

  always_comb begin
    w_refund = (i_cancel && w_credit_nz) || w_timeout;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state != StIdle) || w_refund || w_item_ok || w_pulse || !w_credit_nz) begin
      r_idle_cnt <= '0;
    end else begin
      r_idle_cnt <= r_idle_cnt + 1'b1;
    end
  end
`else
  always_comb begin
    w_refund = i_cancel && w_credit_nz;
  end
`endif

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= StIdle;
      r_credit       <= '0;
      r_sel          <= '0;
      r_disp_cnt     <= '0;
      r_dispense_en  <= 1'b0;
      r_busy         <= 1'b0;
      r_coin_reject  <= 1'b0;
      r_deny         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_amt   <= '0;
    end else begin
      // Pulse outputs default low each cycle.
      r_coin_reject  <= 1'b0;
      r_deny         <= 1'b0;
      r_change_valid <= 1'b0;
      r_change_amt   <= '0;

      unique case (r_state)
        StIdle: begin
          if (w_refund) begin
            r_state        <= StChange;
            r_busy         <= 1'b1;
            r_change_valid <= 1'b1;
            r_change_amt   <= r_credit;
            r_credit       <= '0;
            r_coin_reject  <= w_coin_any;
          end else if (w_item_ok) begin
            r_state       <= StDispense;
            r_busy        <= 1'b1;
            r_credit      <= r_credit - PriceC;
            r_sel         <= i_item_code;
            r_dispense_en <= 1'b1;
            r_disp_cnt    <= DispLoad;
            r_coin_reject <= w_coin_any;
          end else begin
            r_deny <= i_item_valid;
            // A cancel with no credit does nothing, but still blocks coins that cycle.
            if (w_coin_any) begin
              if (w_coin_fits && !i_cancel) begin
                r_credit <= w_sum[CREDIT_W-1:0];
              end else begin
                r_coin_reject <= 1'b1;
              end
            end
          end
        end

        StDispense: begin
          r_coin_reject <= w_coin_any;
          if (r_disp_cnt == '0) begin
            r_dispense_en <= 1'b0;
            r_sel         <= '0;
            if (w_credit_nz) begin
              r_state        <= StChange;
              r_change_valid <= 1'b1;
              r_change_amt   <= r_credit;
              r_credit       <= '0;
            end else begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end
          end else begin
            r_disp_cnt <= r_disp_cnt - 1'b1;
          end
        end

        StChange: begin
          r_coin_reject <= w_coin_any;
          r_state       <= StIdle;
          r_busy        <= 1'b0;
        end

        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_sel1         = r_sel[0];
  assign o_sel2         = r_sel[1];
  assign o_sel3         = r_sel[2];
  assign o_dispense_en  = r_dispense_en;
  assign o_busy         = r_busy;
  assign o_credit       = r_credit;
  assign o_coin_reject  = r_coin_reject;
  assign o_deny         = r_deny;
  assign o_change_valid = r_change_valid;
  assign o_change_amt   = r_change_amt;

endmodule

// File: tb/tb_vend_select_ctrl.sv
// tb_vend_select_ctrl: scoreboard bench for vend_select_ctrl. The driver applies directed and
// random pulses and, for every clock edge, a transaction-level model schedules the expected
// responses (dispense windows, change, deny, coin rejects, credit, busy) into queues keyed by
// the edge after which they must be visible. A separate monitor pops and compares after each
// edge. Honours VEND_AUTO_REFUND_EN (TIMEOUT_CYCLES is then 8).
module tb_vend_select_ctrl;

  localparam int CW    = 6;
  localparam int MAXC  = 63;
  localparam int PRICE = 15;
  localparam int D     = 4;
`ifdef VEND_AUTO_REFUND_EN
  localparam int TO = 8;
`else
  localparam int TO = 1000;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          coin_5;
  logic          coin_10;
  logic          item_valid;
  logic [2:0]    item_code;
  logic          cancel;
  logic          sel1;
  logic          sel2;
  logic          sel3;
  logic          dispense_en;
  logic          busy;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          deny;
  logic          change_valid;
  logic [CW-1:0] change_amt;

  always #5 clk = ~clk;

  vend_select_ctrl #(
    .CREDIT_W       (CW),
    .MAX_CREDIT     (MAXC),
    .PRICE          (PRICE),
    .DISPENSE_CYCLES(D),
    .TIMEOUT_CYCLES (TO)
  ) u_dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_coin_5      (coin_5),
    .i_coin_10     (coin_10),
    .i_item_valid  (item_valid),
    .i_item_code   (item_code),
    .i_cancel      (cancel),
    .o_sel1        (sel1),
    .o_sel2        (sel2),
    .o_sel3        (sel3),
    .o_dispense_en (dispense_en),
    .o_busy        (busy),
    .o_credit      (credit),
    .o_coin_reject (coin_reject),
    .o_deny        (deny),
    .o_change_valid(change_valid),
    .o_change_amt  (change_amt)
  );

  typedef struct {int k; int v;} ev_t;
  typedef struct {int k; int credit; int busy;} st_t;

  ev_t q_disp[$];
  ev_t q_chg[$];
  int  q_deny[$];
  int  q_rej[$];
  st_t q_st[$];

  int n_checks = 0;
  int n_fail   = 0;
  int drv_k    = 0;
  int mon_k    = 0;
  bit done     = 1'b0;

  // Model state: credit seen after the current edge, first edge at which the machine samples
  // inputs as idle again, edge at which post-vend change empties credit, idle-timeout count.
  int m_credit   = 0;
  int m_free_at  = 0;
  int m_zero_at  = -1;
  int m_idle_cnt = 0;

  task automatic chk(input string name, input int k, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0d expected=%0d", name, k, act, exp);
    end
  endtask

  task automatic model(input int e);
    int add;
    bit fire;
`ifdef VEND_AUTO_REFUND_EN
    bit pulse;
`endif
    add = (coin_5 ? 5 : 0) + (coin_10 ? 10 : 0);
    if (!rst_n) begin
      while (q_disp.size() > 0 && q_disp[$].k >= e) void'(q_disp.pop_back());
      while (q_chg.size() > 0 && q_chg[$].k >= e) void'(q_chg.pop_back());
      m_credit   = 0;
      m_free_at  = e + 1;
      m_zero_at  = -1;
      m_idle_cnt = 0;
    end else begin
      if (e == m_zero_at) begin
        m_credit  = 0;
        m_zero_at = -1;
      end
      if (e >= m_free_at) begin
        fire = cancel && (m_credit > 0);
`ifdef VEND_AUTO_REFUND_EN
        pulse = coin_5 || coin_10 || item_valid || cancel;
        if (!pulse && m_credit > 0) begin
          m_idle_cnt++;
          if (m_idle_cnt >= TO) fire = 1'b1;
        end else begin
          m_idle_cnt = 0;
        end
`endif
        if (fire) begin
          q_chg.push_back('{e, m_credit});
          m_credit   = 0;
          m_free_at  = e + 2;
          m_idle_cnt = 0;
          if (add > 0) q_rej.push_back(e);
        end else if (item_valid && m_credit >= PRICE) begin
          m_credit = m_credit - PRICE;
          for (int i = 0; i < D; i++) q_disp.push_back('{e + i, int'(item_code)});
          if (m_credit > 0) begin
            q_chg.push_back('{e + D, m_credit});
            m_zero_at = e + D;
            m_free_at = e + D + 2;
          end else begin
            m_free_at = e + D + 1;
          end
          m_idle_cnt = 0;
          if (add > 0) q_rej.push_back(e);
        end else begin
          if (item_valid) q_deny.push_back(e);
          if (add > 0) begin
            if (!cancel && m_credit + add <= MAXC) m_credit = m_credit + add;
            else q_rej.push_back(e);
          end
        end
      end else begin
        m_idle_cnt = 0;
        if (add > 0) q_rej.push_back(e);
      end
    end
    q_st.push_back('{e, m_credit, (e + 1 < m_free_at) ? 1 : 0});
  endtask

  task automatic cyc(input bit rst, input bit c5, input bit c10, input bit iv,
                     input logic [2:0] code, input bit can);
    rst_n      = ~rst;
    coin_5     = c5;
    coin_10    = c10;
    item_valid = iv;
    item_code  = code;
    cancel     = can;
    model(drv_k);
    drv_k++;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic coin10(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic check_edge(input int k);
    st_t s;
    bit  exp;
    if (q_st.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL state_queue edge=%0d got=empty expected=entry", k);
      return;
    end
    s = q_st.pop_front();
    chk("credit", k, 32'(credit), s.credit);
    chk("busy", k, 32'(busy), s.busy);

    exp = (q_disp.size() > 0) && (q_disp[0].k == k);
    chk("dispense_en", k, 32'(dispense_en), 32'(exp));
    chk("sel", k, 32'({sel3, sel2, sel1}), exp ? q_disp[0].v : 0);
    if (exp) void'(q_disp.pop_front());

    exp = (q_chg.size() > 0) && (q_chg[0].k == k);
    chk("change_valid", k, 32'(change_valid), 32'(exp));
    chk("change_amt", k, 32'(change_amt), exp ? q_chg[0].v : 0);
    if (exp) void'(q_chg.pop_front());

    exp = (q_deny.size() > 0) && (q_deny[0] == k);
    chk("deny", k, 32'(deny), 32'(exp));
    if (exp) void'(q_deny.pop_front());

    exp = (q_rej.size() > 0) && (q_rej[0] == k);
    chk("coin_reject", k, 32'(coin_reject), 32'(exp));
    if (exp) void'(q_rej.pop_front());
  endtask

  // Monitor: compares every edge's outputs 1 time unit after the edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!done) check_edge(mon_k);
      mon_k++;
    end
  end

  initial begin
    // Reset.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(1);

    // 10 + 5, vend code 5, no change.
    coin10(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd5, 1'b0);
    idle(6);

    // 20, vend code 2, change 5.
    coin10(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd2, 1'b0);
    idle(7);

    // 5, denied code 7, then cancel refunds 5.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 1'b0);
    idle(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    idle(2);

    // Saturation at 60: coin_5 and coin_10 rejected, then cancel.
    coin10(6);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    coin10(1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    idle(2);

    // Coin during dispense is rejected.
    coin10(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 1'b0);
    coin10(1);
    idle(6);

    // Cancel wins over item with credit 20.
    coin10(2);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd4, 1'b1);
    idle(2);

    // Item with coin_10 at credit 15: vend, coin rejected.
    coin10(1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 3'd6, 1'b0);
    idle(6);

    // Reset in the 2nd dispense cycle discards remaining credit.
    coin10(3);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    idle(1);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(2);

    // Untouched credit: refunded after the timeout when enabled, otherwise held.
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
    idle(12);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1);
    idle(2);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 199) == 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
          $urandom_range(0, 6) == 0, 3'($urandom_range(0, 7)), $urandom_range(0, 24) == 0);
    end
    idle(12);

    done = 1'b1;
    chk("leftover_dispense", drv_k, q_disp.size(), 0);
    chk("leftover_change", drv_k, q_chg.size(), 0);
    chk("leftover_deny", drv_k, q_deny.size(), 0);
    chk("leftover_reject", drv_k, q_rej.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
